stop_watch_lap: RTL
===================

Name: stop_watch_lap

Overview:
- Parametrised next-generation stopwatch core for the 100 Hz FPGA top level.
- Counts centiseconds, seconds, minutes and optionally hours in BCD, with a configurable digit count.
- Adds a lap/split display freeze, a clear-from-stop control and a sticky overflow flag.
- Drives packed 7-segment patterns plus a state code directly from synchronised push-button inputs.

Parameters:
- NUM_DIGITS, 6, number of BCD display digits; must be even, legal values 4, 6 or 8.
- TICK_DIV, 1, clock cycles per centisecond tick; 1 when clk = hz100; must be at least 1.

Ports:
- clk  input  1  system clock (hz100 at top level).
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  start/stop push button, raw level.
- lap_i  input  1  lap/clear push button, raw level.
- state_o  output  3  current FSM state code.
- bcd_o  output  4*NUM_DIGITS  displayed time in BCD; digit 0 in bits [3:0] is hundredths.
- seg_o  output  7*NUM_DIGITS  7-segment patterns, active-high, bit order gfedcba; digit k in bits [7k+6:7k].
- ovf_o  output  1  sticky overflow flag.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Sync flops, prescaler, count, lap latch and ovf_o all go to 0.
  - state_o = CLEAR (3'd0), bcd_o = 0, every seg_o digit = 7'h3F.
- Input path: each button passes through a 2-flop synchroniser, then a third flop used for rising-edge detection.
  - An edge is a one-cycle pulse: sync2 & ~sync3.
  - A level held high produces exactly one edge.
  - The state change is visible 3 clock edges after the first edge that samples the button high.
- Digit moduli:
  - Pair 0 (centiseconds): 00-99.
  - Pair 1 (seconds): 00-59.
  - Pair 2 (minutes): 00-59.
  - Pair 3 (hours): 00-99.
  - A ones digit carries into its tens digit; a full pair carries into the next pair.
- FSM states:
  - CLEAR = 0
  - RUNNING = 1
  - STOPPED = 2
  - LAP = 3
  - Codes 4-7 are unused; any unused code returns to CLEAR on the next edge.
- Transitions:
  - CLEAR: start edge -> RUNNING. Lap edge ignored.
  - RUNNING: start edge -> STOPPED. Lap edge -> LAP, and the lap latch captures the current count on the same edge.
  - LAP: start edge -> STOPPED. Lap edge -> RUNNING (live display).
  - STOPPED: start edge -> RUNNING, counting resumes from the held value. Lap edge -> CLEAR, with count, prescaler and ovf_o zeroed on the same edge.
  - Both edges in the same cycle: start wins, lap is discarded.
- Prescaler:
  - Runs only in RUNNING and LAP.
  - Holds its value in STOPPED; zeroed in CLEAR.
  - tick = (prescaler == TICK_DIV-1), after which the prescaler wraps to 0.
- Count:
  - Increments by one centisecond on each clock edge where the registered state is RUNNING or LAP and tick = 1.
  - With TICK_DIV = 1, the first increment lands on the edge after the state enters RUNNING.
- Overflow:
  - A tick at the all-maximum value (59:59.99 for 6 digits, 59.99 for 4, 99:59:59.99 for 8) wraps the count to all-zero.
  - The same tick sets ovf_o; it stays set until CLEAR or reset.
  - Counting continues after overflow.
- Display selection:
  - bcd_o = lap latch while in LAP; otherwise the live count.
  - The count keeps advancing underneath while in LAP.
  - seg_o is a combinational decode of bcd_o. BCD values 10-15 cannot occur; decode them to 7'h00.
- Reset during RUNNING or LAP takes priority over any button edge in that cycle.

Test Plan:
- Reset, then start pulse 5 cycles wide -> state_o goes 0->1 three edges after the press, stays 1, and only one transition occurs. bcd_o = 0x000001 on the following edge.
- Run 6123 ticks from CLEAR -> bcd_o = 0x010123 (01:01.23), then start press -> state_o = 2 and bcd_o frozen.
- In RUNNING at 0x000250, press lap, wait 100 cycles -> bcd_o holds 0x000250 with state_o = 3. Press lap again -> bcd_o shows live 0x000350 + 3-cycle sync latency.
- In STOPPED, assert start and lap in the same cycle -> state_o = 1 and count unchanged. A later STOPPED + lap press -> state_o = 0, bcd_o = 0, seg_o = all 7'h3F.
- Preload to 0x595999 via run, then one tick -> bcd_o = 0x000000 and ovf_o = 1. ovf_o stays 1 through stop/start and clears only on CLEAR.
- Pulse reset mid-RUNNING with TICK_DIV = 4 -> next edge gives state_o = 0, bcd_o = 0, ovf_o = 0. After a restart, the count advances once every 4 cycles.

Source files
------------

// File: rtl/stop_watch_lap.sv
// Stopwatch core: BCD time count with lap freeze, clear-from-stop and sticky overflow,
// driven by synchronised push buttons and decoded to packed 7-segment patterns.
module stop_watch_lap #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic                      lap_i,
    output logic [2:0]                state_o,
    output logic [4*NUM_DIGITS-1:0]   bcd_o,
    output logic [7*NUM_DIGITS-1:0]   seg_o,
    output logic                      ovf_o
);

    localparam logic [2:0] S_CLEAR   = 3'd0;
    localparam logic [2:0] S_RUNNING = 3'd1;
    localparam logic [2:0] S_STOPPED = 3'd2;
    localparam logic [2:0] S_LAP     = 3'd3;

    localparam int              BW      = 4 * NUM_DIGITS;
    localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);

    logic [2:0]     start_sync_q, start_sync_d;
    logic [2:0]     lap_sync_q, lap_sync_d;
    logic [2:0]     state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [BW-1:0]  count_q, count_d;
    logic [BW-1:0]  lap_q, lap_d;
    logic           ovf_q, ovf_d;

    logic           start_edge;
    logic           lap_edge;
    logic           counting;
    logic           tick;
    logic [BW-1:0]  count_inc;
    logic           count_wrap;

    // Bit 0 and 1 form the synchroniser; bit 2 is the previous synchronised level.
    assign start_sync_d = {start_sync_q[1:0], start_i};
    assign lap_sync_d   = {lap_sync_q[1:0], lap_i};
    assign start_edge   = start_sync_q[1] & ~start_sync_q[2];
    assign lap_edge     = lap_sync_q[1] & ~lap_sync_q[2];

    assign counting = (state_q == S_RUNNING) || (state_q == S_LAP);
    assign tick     = (presc_q == PRE_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: begin
                if (start_edge) state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (start_edge)    state_d = S_STOPPED;
                else if (lap_edge) state_d = S_LAP;
            end
            S_LAP: begin
                if (start_edge)    state_d = S_STOPPED;
                else if (lap_edge) state_d = S_RUNNING;
            end
            S_STOPPED: begin
                if (start_edge)    state_d = S_RUNNING;
                else if (lap_edge) state_d = S_CLEAR;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Ripple a +1 through the digits; odd digits of pairs 1 and 2 are tens of 00-59.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        logic [3:0] dmax;
        count_inc = count_q;
        carry     = 1'b1;
        dig       = 4'd0;
        dmax      = 4'd9;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            dig  = count_q[4*d +: 4];
            dmax = ((d % 2 == 1) && ((d / 2 == 1) || (d / 2 == 2))) ? 4'd5 : 4'd9;
            if (carry) begin
                if (dig == dmax) begin
                    count_inc[4*d +: 4] = 4'd0;
                end else begin
                    count_inc[4*d +: 4] = dig + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        count_wrap = carry;
    end

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                count_d = count_inc;
                if (count_wrap) ovf_d = 1'b1;
            end
        end
        if ((state_q == S_RUNNING) && (state_d == S_LAP)) lap_d = count_q;
        // Entering or staying in CLEAR wipes the time base and the overflow flag.
        if (state_d == S_CLEAR) begin
            presc_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_sync_q <= '0;
            lap_sync_q   <= '0;
            state_q      <= S_CLEAR;
            presc_q      <= '0;
            count_q      <= '0;
            lap_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            start_sync_q <= start_sync_d;
            lap_sync_q   <= lap_sync_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            ovf_q        <= ovf_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign state_o = state_q;
    assign ovf_o   = ovf_q;
    assign bcd_o   = (state_q == S_LAP) ? lap_q : count_q;

    always_comb begin
        seg_o = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_o[7*k +: 7] = seg7(bcd_o[4*k +: 4]);
        end
    end

endmodule
